// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles the issue-stage handshakes and register file ports.
//   Upstream : inValid/inReady with inSrcA, inSrcB, inDst, inWrites
//   Regfile  : rfSrcA/rfSrcB read addresses, rfDataA/rfDataB read data (one edge late)
//   Writeback: wbValid, wbDst, wbData (also the register file write port)
//   Execute  : outValid/outReady with outDataA, outDataB, outDst, outWrites
// The slave modport is the operand_fetch view; master is the surrounding pipeline.
interface operand_fetch_if #(parameter int WordSize = 32);
    logic                inValid;
    logic                inReady;
    logic [4:0]          inSrcA;
    logic [4:0]          inSrcB;
    logic [4:0]          inDst;
    logic                inWrites;
    logic [4:0]          rfSrcA;
    logic [4:0]          rfSrcB;
    logic [WordSize-1:0] rfDataA;
    logic [WordSize-1:0] rfDataB;
    logic                wbValid;
    logic [4:0]          wbDst;
    logic [WordSize-1:0] wbData;
    logic                outValid;
    logic                outReady;
    logic [WordSize-1:0] outDataA;
    logic [WordSize-1:0] outDataB;
    logic [4:0]          outDst;
    logic                outWrites;

    modport slave (
        input  inValid, inSrcA, inSrcB, inDst, inWrites,
        input  rfDataA, rfDataB,
        input  wbValid, wbDst, wbData,
        input  outReady,
        output inReady, rfSrcA, rfSrcB,
        output outValid, outDataA, outDataB, outDst, outWrites
    );

    modport master (
        output inValid, inSrcA, inSrcB, inDst, inWrites,
        output rfDataA, rfDataB,
        output wbValid, wbDst, wbData,
        output outReady,
        input  inReady, rfSrcA, rfSrcB,
        input  outValid, outDataA, outDataB, outDst, outWrites
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage in front of the register file with a 31-entry scoreboard.
//   clk    : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : operand_fetch_if.slave (upstream, regfile read, writeback, execute)
// Holds at most one instruction. RAW/WAW hazards against in-flight writers stall
// the upstream handshake until writeback clears the busy bit.
// Optional feature macro OPERAND_FETCH_BYPASS_EN: a source retiring this cycle is
// not a hazard; its writeback data is captured and used for the first ISSUE cycle.
module operand_fetch #(
    parameter int WordSize = 32
) (
    input logic            clk,
    input logic            nReset,
    operand_fetch_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state_q, state_d;
    logic [31:1]   busy_q, busy_d;
    logic [4:0]    src_a_q, src_a_d;
    logic [4:0]    src_b_q, src_b_d;
    logic [4:0]    dst_q, dst_d;
    logic          writes_q, writes_d;
    logic [31:0]   busy_vec;
    logic [31:0]   clr_vec;
    logic [31:0]   set_vec;
    logic [31:0]   live_vec;
    logic [31:0]   next_vec;
    logic          hazard;
    logic          ready;
    logic          accept;
    logic [WordSize-1:0] opnd_a;
    logic [WordSize-1:0] opnd_b;
`ifdef OPERAND_FETCH_BYPASS_EN
    logic                byp_a_q, byp_a_d;
    logic                byp_b_q, byp_b_d;
    logic [WordSize-1:0] byp_data_a_q, byp_data_a_d;
    logic [WordSize-1:0] byp_data_b_q, byp_data_b_d;
`endif

    always_comb begin
        // bit 0 is tied low so x0 is never busy and indices need no range guard
        busy_vec = {busy_q, 1'b0};
        clr_vec  = (bus.wbValid && bus.wbDst != 5'd0) ? (32'd1 << bus.wbDst) : 32'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
        // a source retiring this edge can be forwarded, so it is no longer a hazard
        live_vec = busy_vec & ~clr_vec;
`else
        live_vec = busy_vec;
`endif
        // destination check stays strict so each register has one pending writer
        hazard   = live_vec[bus.inSrcA] || live_vec[bus.inSrcB] ||
                   (bus.inWrites && busy_vec[bus.inDst]);
        ready    = nReset && !hazard && (state_q == IDLE || bus.outReady);
        accept   = bus.inValid && ready;
        set_vec  = (accept && bus.inWrites && bus.inDst != 5'd0) ? (32'd1 << bus.inDst) : 32'd0;
        // set after clear: a new writer wins over a retiring one on the same index
        next_vec = (busy_vec & ~clr_vec) | set_vec;
        busy_d   = next_vec[31:1];
        state_d  = accept ? ISSUE :
                   (state_q == ISSUE && bus.outReady) ? IDLE : state_q;
        src_a_d  = accept ? bus.inSrcA : src_a_q;
        src_b_d  = accept ? bus.inSrcB : src_b_q;
        dst_d    = accept ? bus.inDst : dst_q;
        writes_d = accept ? bus.inWrites : writes_q;
`ifdef OPERAND_FETCH_BYPASS_EN
        // regfile read on the accept edge returns the pre-write value, so the
        // retiring data is needed only for the first ISSUE cycle
        byp_a_d      = accept && clr_vec[bus.inSrcA];
        byp_b_d      = accept && clr_vec[bus.inSrcB];
        byp_data_a_d = accept ? bus.wbData : byp_data_a_q;
        byp_data_b_d = accept ? bus.wbData : byp_data_b_q;
        opnd_a       = (src_a_q == 5'd0) ? '0 : byp_a_q ? byp_data_a_q : bus.rfDataA;
        opnd_b       = (src_b_q == 5'd0) ? '0 : byp_b_q ? byp_data_b_q : bus.rfDataB;
`else
        opnd_a       = (src_a_q == 5'd0) ? '0 : bus.rfDataA;
        opnd_b       = (src_b_q == 5'd0) ? '0 : bus.rfDataB;
`endif
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            busy_q   <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            writes_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            writes_q <= writes_d;
        end
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            byp_a_q      <= 1'b0;
            byp_b_q      <= 1'b0;
            byp_data_a_q <= '0;
            byp_data_b_q <= '0;
        end else begin
            byp_a_q      <= byp_a_d;
            byp_b_q      <= byp_b_d;
            byp_data_a_q <= byp_data_a_d;
            byp_data_b_q <= byp_data_b_d;
        end
    end
`endif

    // the read address follows the incoming instruction only when it is taken,
    // otherwise it stays on the held sources so the read data does not move
    assign bus.inReady   = ready;
    assign bus.rfSrcA    = accept ? bus.inSrcA : src_a_q;
    assign bus.rfSrcB    = accept ? bus.inSrcB : src_b_q;
    assign bus.outValid  = (state_q == ISSUE);
    assign bus.outDataA  = bus.outValid ? opnd_a : '0;
    assign bus.outDataB  = bus.outValid ? opnd_b : '0;
    assign bus.outDst    = dst_q;
    assign bus.outWrites = writes_q;
endmodule
